// File: rtl/hbm_bench_pkg.sv
// Shared types and limits for the HBM benchmark sequencer.
// The optional watchdog is enabled by defining HBM_SEQ_TIMEOUT_EN.
package hbm_bench_pkg;

  localparam int N_MEM_INTF_MAX = 32;
  localparam int CNT_W_DEF      = 64;
  localparam int TIMEOUT_W_DEF  = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_LAUNCH = 3'd1,
    S_WR_WAIT   = 3'd2,
    S_RD_LAUNCH = 3'd3,
    S_RD_WAIT   = 3'd4,
    S_DONE      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/hbm_lowbit_select.sv
// Combinational one-hot extractor of the lowest set bit of a channel mask.
module hbm_lowbit_select #(
  parameter int N = 32
) (
  input  logic [N-1:0] vec_i,
  output logic [N-1:0] onehot_o
);

  logic found;

  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i] && !found) begin
        onehot_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hbm_bench_sequencer.sv
// Sequences an HBM benchmark run: write phase then read phase, parallel or serial.
// Optional per-WAIT watchdog enabled by defining HBM_SEQ_TIMEOUT_EN.
module hbm_bench_sequencer
  import hbm_bench_pkg::*;
#(
  parameter int N_MEM_INTF = N_MEM_INTF_MAX,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
  input  logic                  hbm_axi_clk,
  input  logic                  hbm_reset,
  input  logic                  start,
  input  logic                  serial_mode,
  input  logic [N_MEM_INTF-1:0] write_enable,
  input  logic [N_MEM_INTF-1:0] read_enable,
  input  logic [N_MEM_INTF-1:0] end_wr,
  input  logic [N_MEM_INTF-1:0] end_rd,
`ifdef HBM_SEQ_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic                  timed_out,
`endif
  output logic [N_MEM_INTF-1:0] chan_start_wr,
  output logic [N_MEM_INTF-1:0] chan_start_rd,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      wr_cycles,
  output logic [CNT_W-1:0]      rd_cycles,
  output seq_state_e            dbg_state
);

  seq_state_e            state_q, state_d;
  logic                  start_q, serial_q, serial_d;
  logic [N_MEM_INTF-1:0] end_wr_q, end_rd_q;
  logic [N_MEM_INTF-1:0] wr_rem_q, wr_rem_d, rd_rem_q, rd_rem_d;
  logic [N_MEM_INTF-1:0] pend_q, pend_d;
  logic [N_MEM_INTF-1:0] wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic                  start_rise, in_rd, wd_hit;
  logic [N_MEM_INTF-1:0] cur_rem, cur_low, launch_vec, cur_done, pend_left;

`ifdef HBM_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic                  to_q, to_d;
  assign wd_hit    = (timeout_limit != '0) && ((wd_q + TIMEOUT_W'(1)) == timeout_limit)
                     && (state_q inside {S_WR_WAIT, S_RD_WAIT});
  assign timed_out = to_q;
`else
  assign wd_hit = 1'b0;
`endif

  assign start_rise = start & ~start_q;
  assign in_rd      = state_q inside {S_RD_LAUNCH, S_RD_WAIT};
  assign cur_rem    = in_rd ? rd_rem_q : wr_rem_q;
  assign launch_vec = serial_q ? cur_low : cur_rem;

  // A completion needs a fresh end edge after the pulse cycle of that channel.
  assign cur_done  = pend_q & (in_rd ? (end_rd & ~end_rd_q & ~rd_pulse_q)
                                     : (end_wr & ~end_wr_q & ~wr_pulse_q));
  assign pend_left = pend_q & ~cur_done;

  hbm_lowbit_select #(.N(N_MEM_INTF)) u_lowbit (
    .vec_i    (cur_rem),
    .onehot_o (cur_low)
  );

  // State register
  always_ff @(posedge hbm_axi_clk) begin
    if (hbm_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_rise) state_d = S_WR_LAUNCH;
      S_WR_LAUNCH: state_d = (wr_rem_q == '0) ? S_RD_LAUNCH : S_WR_WAIT;
      S_WR_WAIT: begin
        if (wd_hit)                 state_d = S_DONE;
        else if (pend_left == '0)   state_d = (wr_rem_q != '0) ? S_WR_LAUNCH : S_RD_LAUNCH;
      end
      S_RD_LAUNCH: state_d = (rd_rem_q == '0) ? S_DONE : S_RD_WAIT;
      S_RD_WAIT: begin
        if (wd_hit)                 state_d = S_DONE;
        else if (pend_left == '0)   state_d = (rd_rem_q != '0) ? S_RD_LAUNCH : S_DONE;
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    serial_d   = serial_q;
    wr_rem_d   = wr_rem_q;
    rd_rem_d   = rd_rem_q;
    pend_d     = pend_q;
    wr_pulse_d = '0;
    rd_pulse_d = '0;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef HBM_SEQ_TIMEOUT_EN
    wd_d       = wd_q;
    to_d       = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          serial_d = serial_mode;
          wr_rem_d = write_enable;
          rd_rem_d = read_enable;
          pend_d   = '0;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
`ifdef HBM_SEQ_TIMEOUT_EN
          to_d     = 1'b0;
`endif
        end
      end
      S_WR_LAUNCH, S_RD_LAUNCH: begin
        if (cur_rem != '0) begin
          pend_d = launch_vec;
          if (in_rd) begin
            rd_pulse_d = launch_vec;
            rd_rem_d   = rd_rem_q & ~launch_vec;
            if (~&rd_cnt_q) rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end else begin
            wr_pulse_d = launch_vec;
            wr_rem_d   = wr_rem_q & ~launch_vec;
            if (~&wr_cnt_q) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
`ifdef HBM_SEQ_TIMEOUT_EN
          wd_d = '0;
`endif
        end
      end
      S_WR_WAIT, S_RD_WAIT: begin
        pend_d = pend_left;
        if (in_rd) begin
          if (~&rd_cnt_q) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else begin
          if (~&wr_cnt_q) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
`ifdef HBM_SEQ_TIMEOUT_EN
        wd_d = wd_q + TIMEOUT_W'(1);
        if (wd_hit) begin
          pend_d   = '0;
          wr_rem_d = '0;
          rd_rem_d = '0;
          to_d     = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    if (state_d == S_DONE && state_q != S_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pend_d = '0;
    end
  end

  always_ff @(posedge hbm_axi_clk) begin
    if (hbm_reset) begin
      start_q    <= 1'b0;
      serial_q   <= 1'b0;
      end_wr_q   <= '0;
      end_rd_q   <= '0;
      wr_rem_q   <= '0;
      rd_rem_q   <= '0;
      pend_q     <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef HBM_SEQ_TIMEOUT_EN
      wd_q       <= '0;
      to_q       <= 1'b0;
`endif
    end else begin
      start_q    <= start;
      serial_q   <= serial_d;
      end_wr_q   <= end_wr;
      end_rd_q   <= end_rd;
      wr_rem_q   <= wr_rem_d;
      rd_rem_q   <= rd_rem_d;
      pend_q     <= pend_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef HBM_SEQ_TIMEOUT_EN
      wd_q       <= wd_d;
      to_q       <= to_d;
`endif
    end
  end

  assign chan_start_wr = wr_pulse_q;
  assign chan_start_rd = rd_pulse_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_cycles     = wr_cnt_q;
  assign rd_cycles     = rd_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_hbm_bench_sequencer.sv
// Directed self-checking bench for hbm_bench_sequencer (default 32 channels, 64-bit counters).
// Watchdog scenario is included when HBM_SEQ_TIMEOUT_EN is defined.
module tb_hbm_bench_sequencer;
  import hbm_bench_pkg::*;

  localparam int N = 32;
  localparam int CW = 64;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          hbm_reset, start, serial_mode;
  logic [N-1:0]  write_enable, read_enable, end_wr, end_rd;
  logic [N-1:0]  chan_start_wr, chan_start_rd;
  logic          busy, done;
  logic [CW-1:0] wr_cycles, rd_cycles;
  seq_state_e    dbg_state;
`ifdef HBM_SEQ_TIMEOUT_EN
  logic [TW-1:0] timeout_limit;
  logic          timed_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hbm_bench_sequencer #(.N_MEM_INTF(N), .CNT_W(CW), .TIMEOUT_W(TW)) dut (
    .hbm_axi_clk   (clk),
    .hbm_reset     (hbm_reset),
    .start         (start),
    .serial_mode   (serial_mode),
    .write_enable  (write_enable),
    .read_enable   (read_enable),
    .end_wr        (end_wr),
    .end_rd        (end_rd),
`ifdef HBM_SEQ_TIMEOUT_EN
    .timeout_limit (timeout_limit),
    .timed_out     (timed_out),
`endif
    .chan_start_wr (chan_start_wr),
    .chan_start_rd (chan_start_rd),
    .busy          (busy),
    .done          (done),
    .wr_cycles     (wr_cycles),
    .rd_cycles     (rd_cycles),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hbm_reset = 1'b1;
    tick();
    tick();
    hbm_reset = 1'b0;
  endtask

  // Drop start and end levels so edge history is clean before a run
  task automatic idle_inputs();
    start  = 1'b0;
    end_wr = '0;
    end_rd = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({chan_start_wr, chan_start_rd, busy, done} !== '0 || wr_cycles !== '0 || rd_cycles !== '0) begin
      $display("FAIL reset_outputs: wr=%0h rd=%0h busy=%0b done=%0b wc=%0d rc=%0d exp all 0",
               chan_start_wr, chan_start_rd, busy, done, wr_cycles, rd_cycles);
      n_fail++;
    end
    n_tests++;
    if (dbg_state !== S_IDLE) begin
      $display("FAIL reset_state: got %0d exp %0d", dbg_state, S_IDLE);
      n_fail++;
    end
  endtask

  task automatic test_parallel();
    idle_inputs();
    serial_mode = 1'b0; write_enable = 32'hF; read_enable = 32'hF;
    start = 1'b1;
    tick();
    n_tests++;
    if (chan_start_wr !== '0 || busy !== 1'b1) begin
      $display("FAIL par_accept: pulse=%0h busy=%0b exp pulse=0 busy=1", chan_start_wr, busy);
      n_fail++;
    end
    tick();
    n_tests++;
    if (chan_start_wr !== 32'hF) begin
      $display("FAIL par_wr_pulse: got %0h exp f", chan_start_wr);
      n_fail++;
    end
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 10) end_wr[0] = 1'b1;
      if (c == 12) end_wr[1] = 1'b1;
      if (c == 15) end_wr[2] = 1'b1;
      if (c == 20) end_wr[3] = 1'b1;
      if (c == 23) end_rd    = 32'hF;
      if (c == 1) begin
        n_tests++;
        if (chan_start_wr !== '0) begin
          $display("FAIL par_single_pulse: got %0h exp 0", chan_start_wr);
          n_fail++;
        end
      end
      if (c == 21) begin
        n_tests++;
        if (chan_start_rd !== '0 || dbg_state !== S_RD_LAUNCH) begin
          $display("FAIL par_rd_latency: rd=%0h state=%0d exp rd=0 state=%0d", chan_start_rd, dbg_state, S_RD_LAUNCH);
          n_fail++;
        end
      end
      if (c == 22) begin
        n_tests++;
        if (chan_start_rd !== 32'hF || wr_cycles !== 64'd22) begin
          $display("FAIL par_rd_pulse: rd=%0h wc=%0d exp rd=f wc=22", chan_start_rd, wr_cycles);
          n_fail++;
        end
      end
      if (c == 24) begin
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_cycles !== 64'd3 || wr_cycles !== 64'd22) begin
          $display("FAIL par_done: done=%0b busy=%0b rc=%0d wc=%0d exp 1 0 3 22", done, busy, rd_cycles, wr_cycles);
          n_fail++;
        end
      end
      if (c == 25) begin
        n_tests++;
        if (dbg_state !== S_IDLE || done !== 1'b1) begin
          $display("FAIL par_done_hold: state=%0d done=%0b exp %0d 1", dbg_state, done, S_IDLE);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_serial();
    idle_inputs();
    serial_mode = 1'b1; write_enable = 32'h5; read_enable = 32'h0;
    start = 1'b1;
    tick();
    tick();
    n_tests++;
    if (chan_start_wr !== 32'h1) begin
      $display("FAIL ser_first_pulse: got %0h exp 1", chan_start_wr);
      n_fail++;
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) end_wr[0] = 1'b1;
      if (c == 4) end_wr[2] = 1'b1;  // same cycle as its launch pulse: must be ignored
      if (c == 5) end_wr[2] = 1'b0;
      if (c == 6) end_wr[2] = 1'b1;
      if (c == 3) begin
        n_tests++;
        if (chan_start_wr !== '0 || dbg_state !== S_WR_LAUNCH) begin
          $display("FAIL ser_gap: pulse=%0h state=%0d exp 0 %0d", chan_start_wr, dbg_state, S_WR_LAUNCH);
          n_fail++;
        end
      end
      if (c == 4) begin
        n_tests++;
        if (chan_start_wr !== 32'h4) begin
          $display("FAIL ser_second_pulse: got %0h exp 4", chan_start_wr);
          n_fail++;
        end
      end
      if (c == 5) begin
        n_tests++;
        if (dbg_state !== S_WR_WAIT) begin
          $display("FAIL ser_same_cycle_edge: state=%0d exp %0d", dbg_state, S_WR_WAIT);
          n_fail++;
        end
      end
      if (c == 8) begin
        n_tests++;
        if (done !== 1'b1 || wr_cycles !== 64'd8 || rd_cycles !== '0 || chan_start_rd !== '0) begin
          $display("FAIL ser_done: done=%0b wc=%0d rc=%0d rd=%0h exp 1 8 0 0", done, wr_cycles, rd_cycles, chan_start_rd);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_stale();
    idle_inputs();
    end_wr[0] = 1'b1;
    tick();
    tick();
    serial_mode = 1'b0; write_enable = 32'h1; read_enable = 32'h0;
    start = 1'b1;
    tick();
    tick();
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) begin
        n_tests++;
        if (dbg_state !== S_WR_WAIT || busy !== 1'b1) begin
          $display("FAIL stale_ignored: state=%0d busy=%0b exp %0d 1", dbg_state, busy, S_WR_WAIT);
          n_fail++;
        end
        end_wr[0] = 1'b0;
      end
      if (c == 4) end_wr[0] = 1'b1;
      if (c == 6) begin
        n_tests++;
        if (done !== 1'b1 || wr_cycles !== 64'd6) begin
          $display("FAIL stale_fresh_edge: done=%0b wc=%0d exp 1 6", done, wr_cycles);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    serial_mode = 1'b0; write_enable = 32'h3; read_enable = 32'h0;
    start = 1'b1;
    tick();
    tick();
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0;
        end_wr[5] = 1'b1;
      end
      if (c == 2) begin
        start = 1'b1;
        write_enable = 32'hFF;
      end
      if (c == 3) begin
        n_tests++;
        if (dbg_state !== S_WR_WAIT || chan_start_wr !== '0 || busy !== 1'b1) begin
          $display("FAIL busy_restart_ignored: state=%0d pulse=%0h busy=%0b exp %0d 0 1",
                   dbg_state, chan_start_wr, busy, S_WR_WAIT);
          n_fail++;
        end
        end_wr[1:0] = 2'b11;
      end
      if (c == 5) begin
        n_tests++;
        if (done !== 1'b1 || wr_cycles !== 64'd5) begin
          $display("FAIL busy_done: done=%0b wc=%0d exp 1 5", done, wr_cycles);
          n_fail++;
        end
      end
      if (c == 7) begin
        n_tests++;
        if (dbg_state !== S_IDLE || busy !== 1'b0) begin
          $display("FAIL busy_no_rerun: state=%0d busy=%0b exp %0d 0", dbg_state, busy, S_IDLE);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    idle_inputs();
    serial_mode = 1'b0; write_enable = 32'h1; read_enable = 32'h2;
    start = 1'b1;
    tick();
    tick();
    tick();
    hbm_reset = 1'b1;
    start = 1'b0;
    tick();
    n_tests++;
    if ({chan_start_wr, chan_start_rd, busy, done} !== '0 || wr_cycles !== '0 || dbg_state !== S_IDLE) begin
      $display("FAIL midrun_reset: wr=%0h rd=%0h busy=%0b done=%0b wc=%0d state=%0d exp all 0 idle",
               chan_start_wr, chan_start_rd, busy, done, wr_cycles, dbg_state);
      n_fail++;
    end
    hbm_reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    tick();
    n_tests++;
    if (chan_start_wr !== 32'h1) begin
      $display("FAIL post_reset_pulse: got %0h exp 1", chan_start_wr);
      n_fail++;
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) end_wr[0] = 1'b1;
      if (c == 3) begin
        n_tests++;
        if (chan_start_rd !== 32'h2) begin
          $display("FAIL post_reset_rd_pulse: got %0h exp 2", chan_start_rd);
          n_fail++;
        end
      end
      if (c == 4) end_rd[1] = 1'b1;
      if (c == 5) begin
        n_tests++;
        if (done !== 1'b1 || wr_cycles !== 64'd3 || rd_cycles !== 64'd3) begin
          $display("FAIL post_reset_done: done=%0b wc=%0d rc=%0d exp 1 3 3", done, wr_cycles, rd_cycles);
          n_fail++;
        end
      end
    end
  endtask

`ifdef HBM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    idle_inputs();
    timeout_limit = 32'd100;
    serial_mode = 1'b0; write_enable = 32'h3; read_enable = 32'h3;
    start = 1'b1;
    tick();
    tick();
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c == 5) end_wr[0] = 1'b1;
      if (c == 99) begin
        n_tests++;
        if (done !== 1'b0 || timed_out !== 1'b0) begin
          $display("FAIL timeout_early: done=%0b to=%0b exp 0 0", done, timed_out);
          n_fail++;
        end
      end
      if (c == 100) begin
        n_tests++;
        if (done !== 1'b1 || timed_out !== 1'b1 || chan_start_rd !== '0) begin
          $display("FAIL timeout_fire: done=%0b to=%0b rd=%0h exp 1 1 0", done, timed_out, chan_start_rd);
          n_fail++;
        end
      end
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    n_tests++;
    if (timed_out !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL timeout_clear: to=%0b busy=%0b exp 0 1", timed_out, busy);
      n_fail++;
    end
    timeout_limit = '0;
    do_reset();
  endtask
`endif

  initial begin
    hbm_reset = 1'b1; start = 1'b0; serial_mode = 1'b0;
    write_enable = '0; read_enable = '0; end_wr = '0; end_rd = '0;
`ifdef HBM_SEQ_TIMEOUT_EN
    timeout_limit = '0;
`endif
    test_reset();
    test_parallel();
    test_serial();
    test_stale();
    test_back_to_back();
    test_reset_midrun();
`ifdef HBM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
